serial_rx_sequencer: RTL and testbench

Oversampling controller for the serial byte-receive path. Samples the asynchronous-protocol line at bit midpoints, validates start and stop bits, assembles 8 data bits LSB-first, and hands completed bytes to the downstream consumer through a valid/ready port with a one-deep holding register. Sits between the external line synchronizer and the byte consumer. Replaces bare done-pulse framing with timed sampling, error recovery and flow control.

---
 rtl/serial_rx_pkg.sv | 21 ++
 rtl/serial_rx_bit_timer.sv | 40 ++++
 rtl/serial_rx_sequencer.sv | 130 +++++++++++++
 tb/tb_serial_rx_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// serial_rx_pkg
//   Shared definitions for the serial byte-receive path: sequencer state
//   encoding, frame data width and the bit-timer counter width helper.
package serial_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    localparam int DATA_BITS = 8;

    // Width of a counter that must hold 0 .. clks-1.
    function automatic int cnt_width(input int clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/serial_rx_bit_timer.sv
// serial_rx_bit_timer
//   Free-running bit-period counter for the receive sequencer. Counts
//   0 .. CLKS_PER_BIT-1 and wraps; the two strobes mark the last cycle of
//   the first half-bit and of a full bit.
// Ports:
//   clk      in   clock, posedge
//   reset    in   synchronous active-high reset, cnt -> 0
//   clear    in   hold/restart the counter at 0 on the next edge
//   half_pt  out  cnt == CLKS_PER_BIT/2 - 1
//   full_pt  out  cnt == CLKS_PER_BIT - 1
module serial_rx_bit_timer
    import serial_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic half_pt,
    output logic full_pt
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // Explicit wrap at FULL_LAST keeps non-power-of-two bit periods exact.
    always_ff @(posedge clk) begin
        if (reset || clear || full_pt)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign half_pt = (cnt == HALF_LAST);
    assign full_pt = (cnt == FULL_LAST);

endmodule

// File: rtl/serial_rx_sequencer.sv
// serial_rx_sequencer
//   Oversampling receive controller. Detects the start edge, samples each
//   bit at its midpoint, checks start/stop framing, assembles 8 data bits
//   LSB-first and presents the byte through a one-deep valid/ready holding
//   register.
// Ports:
//   clk        in   clock, posedge
//   reset      in   synchronous active-high reset
//   din        in   serial line, synchronized to clk, idle high
//   out_data   out  received byte, stable while out_valid and not accepted
//   out_valid  out  byte available
//   out_ready  in   consumer accepts when out_valid & out_ready
//   frame_err  out  one-cycle pulse, stop bit sampled low
//   overrun    out  one-cycle pulse, completed byte dropped (holding full)
module serial_rx_sequencer
    import serial_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 din,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int IW = cnt_width(DATA_BITS);

    state_t               state;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] sr;
    logic                 timer_clear;
    logic                 half_pt;
    logic                 full_pt;

    // The timer idles at zero and is restarted at the start-bit midpoint,
    // so every later full_pt strobe falls in the middle of a bit.
    assign timer_clear = (state == IDLE) || (state == WAIT_IDLE) ||
                         (state == START && half_pt);

    serial_rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .half_pt (half_pt),
        .full_pt (full_pt)
    );

    // NOTE: all state here is updated with non-blocking assignments so every
    // branch reads the pre-edge values of out_valid, sr and idx.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            sr        <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // Flags are single-cycle pulses; a later assignment in this
            // block overrides these defaults for the cycle that raises them.
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // Consumer handshake; a delivery below in the same cycle wins.
            if (out_valid && out_ready)
                out_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (!din)
                        state <= START;
                end

                START: begin
                    if (half_pt) begin
                        if (!din) begin
                            state <= DATA;
                            idx   <= '0;
                        end else begin
                            state <= IDLE;   // glitch shorter than half a bit
                        end
                    end
                end

                DATA: begin
                    if (full_pt) begin
                        sr[idx] <= din;
                        idx     <= idx + IW'(1);
                        if (idx == IW'(DATA_BITS - 1))
                            state <= STOP;
                    end
                end

                STOP: begin
                    if (full_pt) begin
                        if (din) begin
                            state <= IDLE;
                            if (!out_valid || out_ready) begin
                                out_data  <= sr;
                                out_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end
                    end
                end

                WAIT_IDLE: begin
                    // A broken frame may leave the line low; do not treat
                    // that low level as a new start edge.
                    if (din)
                        state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_rx_sequencer.sv
// tb_serial_rx_sequencer
//   Directed bench for serial_rx_sequencer with CLKS_PER_BIT = 16.
//   Frame cycle c = 0 is the edge that first samples the start bit low;
//   the stop bit is sampled at c = 8 + 9*16 = 152 and registered outputs
//   are observed 1 time unit after that edge.
module tb_serial_rx_sequencer;

    localparam int CPB     = 16;
    localparam int FRAME   = 10 * CPB;          // 160 cycles per frame
    localparam int STOP_C  = CPB / 2 + 9 * CPB;  // 152

    logic       clk = 1'b0;
    logic       reset;
    logic       din;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    // Observation record, refreshed by clear_obs and each run_cycle.
    int         cyc;
    int         vld_rise_c;
    logic [7:0] data_at_rise;
    int         vld_cycles;
    int         err_c;
    int         err_cnt;
    int         ovr_c;
    int         ovr_cnt;
    logic       prev_vld;
    logic [7:0] snap_data;
    logic       snap_vld;

    serial_rx_sequencer #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic clear_obs();
        cyc          = 0;
        vld_rise_c   = -1;
        data_at_rise = 8'h00;
        vld_cycles   = 0;
        err_c        = -1;
        err_cnt      = 0;
        ovr_c        = -1;
        ovr_cnt      = 0;
        prev_vld     = out_valid;
        snap_data    = 8'h00;
        snap_vld     = 1'b0;
    endtask

    task automatic run_cycle(input logic d);
        din = d;
        @(posedge clk);
        #1;
        if (out_valid && !prev_vld && vld_rise_c < 0) begin
            vld_rise_c   = cyc;
            data_at_rise = out_data;
        end
        if (out_valid) vld_cycles++;
        if (frame_err) begin
            err_cnt++;
            if (err_c < 0) err_c = cyc;
        end
        if (overrun) begin
            ovr_cnt++;
            if (ovr_c < 0) ovr_c = cyc;
        end
        if (cyc == STOP_C) begin
            snap_data = out_data;
            snap_vld  = out_valid;
        end
        prev_vld = out_valid;
        cyc++;
    endtask

    // Drives ncyc cycles of a frame; out_ready is pulsed high for the single
    // edge at cycle ready_at when ready_at >= 0.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int ready_at, input int ncyc);
        int   bi;
        logic d;
        clear_obs();
        for (int c = 0; c < ncyc; c++) begin
            bi = c / CPB;
            if (bi == 0)      d = 1'b0;
            else if (bi <= 8) d = b[bi-1];
            else              d = stop_bit;
            if (c == ready_at) out_ready = 1'b1;
            run_cycle(d);
            if (c == ready_at) out_ready = 1'b0;
        end
    endtask

    task automatic check_good_frame(input string name, input logic [7:0] exp);
        checks++;
        if (vld_rise_c !== STOP_C) begin
            errors++;
            $display("FAIL %s valid_cycle: got %0d expected %0d", name, vld_rise_c, STOP_C);
        end
        checks++;
        if (data_at_rise !== exp) begin
            errors++;
            $display("FAIL %s data: got %02h expected %02h", name, data_at_rise, exp);
        end
        checks++;
        if (vld_cycles !== 1) begin
            errors++;
            $display("FAIL %s valid_width: got %0d expected 1", name, vld_cycles);
        end
        checks++;
        if (err_cnt !== 0 || ovr_cnt !== 0) begin
            errors++;
            $display("FAIL %s flags: got err=%0d ovr=%0d expected 0 0", name, err_cnt, ovr_cnt);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        din       = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, frame_err, overrun} !== 3'b000 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b e=%b o=%b d=%02h expected 0 0 0 00",
                     out_valid, frame_err, overrun, out_data);
        end
        reset = 1'b0;
        clear_obs();
        repeat (5) run_cycle(1'b1);
        checks++;
        if (vld_cycles !== 0 || err_cnt !== 0) begin
            errors++;
            $display("FAIL reset_idle: got vld=%0d err=%0d expected 0 0", vld_cycles, err_cnt);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_frame(8'hA5, 1'b1, -1, FRAME);
        check_good_frame("basic_a5", 8'hA5);
    endtask

    task automatic test_glitch();
        out_ready = 1'b1;
        clear_obs();
        repeat (4)  run_cycle(1'b0);
        repeat (20) run_cycle(1'b1);
        checks++;
        if (vld_cycles !== 0 || err_cnt !== 0) begin
            errors++;
            $display("FAIL glitch_ignored: got vld=%0d err=%0d expected 0 0", vld_cycles, err_cnt);
        end
        send_frame(8'h3C, 1'b1, -1, FRAME);
        check_good_frame("after_glitch_3c", 8'h3C);
    endtask

    task automatic test_frame_err();
        out_ready = 1'b1;
        send_frame(8'h55, 1'b0, -1, FRAME);
        repeat (40) run_cycle(1'b0);
        checks++;
        if (err_c !== STOP_C) begin
            errors++;
            $display("FAIL frame_err_cycle: got %0d expected %0d", err_c, STOP_C);
        end
        checks++;
        if (err_cnt !== 1) begin
            errors++;
            $display("FAIL frame_err_width: got %0d expected 1", err_cnt);
        end
        checks++;
        if (vld_cycles !== 0 || ovr_cnt !== 0) begin
            errors++;
            $display("FAIL frame_err_no_data: got vld=%0d ovr=%0d expected 0 0", vld_cycles, ovr_cnt);
        end
        repeat (2) run_cycle(1'b1);
        send_frame(8'h0F, 1'b1, -1, FRAME);
        check_good_frame("after_ferr_0f", 8'h0F);
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        send_frame(8'h11, 1'b1, -1, FRAME);
        checks++;
        if (vld_rise_c !== STOP_C || data_at_rise !== 8'h11) begin
            errors++;
            $display("FAIL ovr_first: got cyc=%0d d=%02h expected %0d 11", vld_rise_c, data_at_rise, STOP_C);
        end
        send_frame(8'h22, 1'b1, -1, FRAME);
        checks++;
        if (ovr_c !== STOP_C || ovr_cnt !== 1) begin
            errors++;
            $display("FAIL ovr_pulse: got cyc=%0d n=%0d expected %0d 1", ovr_c, ovr_cnt, STOP_C);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h11 || err_cnt !== 0) begin
            errors++;
            $display("FAIL ovr_held: got v=%b d=%02h err=%0d expected 1 11 0", out_valid, out_data, err_cnt);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h11) begin
            errors++;
            $display("FAIL ovr_accept: got v=%b d=%02h expected 0 11", out_valid, out_data);
        end
    endtask

    task automatic test_back_to_back_accept();
        out_ready = 1'b0;
        send_frame(8'h11, 1'b1, -1, FRAME);
        send_frame(8'h22, 1'b1, STOP_C, FRAME);
        checks++;
        if (ovr_cnt !== 0) begin
            errors++;
            $display("FAIL swap_no_overrun: got %0d expected 0", ovr_cnt);
        end
        checks++;
        if (snap_vld !== 1'b1 || snap_data !== 8'h22) begin
            errors++;
            $display("FAIL swap_load: got v=%b d=%02h expected 1 22", snap_vld, snap_data);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h22) begin
            errors++;
            $display("FAIL swap_held: got v=%b d=%02h expected 1 22", out_valid, out_data);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_frame();
        out_ready = 1'b0;
        send_frame(8'h11, 1'b1, -1, FRAME);
        // Stop driving inside data bit 4 (cycles 80..95) of 0xFF.
        send_frame(8'hFF, 1'b1, -1, 5 * CPB + CPB / 2 + 1);
        reset = 1'b1;
        din   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, frame_err, overrun} !== 3'b000 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL midreset_outputs: got v=%b e=%b o=%b d=%02h expected 0 0 0 00",
                     out_valid, frame_err, overrun, out_data);
        end
        reset     = 1'b0;
        out_ready = 1'b1;
        clear_obs();
        repeat (20) run_cycle(1'b1);
        checks++;
        if (vld_cycles !== 0 || err_cnt !== 0) begin
            errors++;
            $display("FAIL midreset_quiet: got vld=%0d err=%0d expected 0 0", vld_cycles, err_cnt);
        end
        send_frame(8'h81, 1'b1, -1, FRAME);
        check_good_frame("after_reset_81", 8'h81);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back_accept();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
